// File: rtl/hmmm_fetch_pkg.sv
// hmmm_fetch_pkg
// Shared definitions for the instruction-fetch sequencer:
//   DEFAULT_N  - default data bus / PC width
//   INSTR_W    - instruction width for the default bus (two bus words)
//   ST_*       - 3-bit state encodings, also used as the enum values
//   fetch_next - next-state rule of the fetch FSM
package hmmm_fetch_pkg;

  localparam int DEFAULT_N = 8;
  localparam int INSTR_W   = 2 * DEFAULT_N;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_READ_HI = 3'd2;
  localparam logic [2:0] ST_ADDR_LO = 3'd3;
  localparam logic [2:0] ST_READ_LO = 3'd4;
  localparam logic [2:0] ST_ISSUE   = 3'd5;
  localparam logic [2:0] ST_JUMP    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ADDR_HI = ST_ADDR_HI,
    S_READ_HI = ST_READ_HI,
    S_ADDR_LO = ST_ADDR_LO,
    S_READ_LO = ST_READ_LO,
    S_ISSUE   = ST_ISSUE,
    S_JUMP    = ST_JUMP
  } fetch_state_e;

  // Next-state rule. In ISSUE an accept with halt always wins over a
  // branch request, so a halted core never redirects the PC.
  function automatic fetch_state_e fetch_next(
    input fetch_state_e cur,
    input logic         run,
    input logic         mem_ready,
    input logic         instr_ready,
    input logic         halt,
    input logic         branch_req
  );
    fetch_state_e nxt;
    nxt = cur;
    case (cur)
      S_IDLE:    if (run) nxt = S_ADDR_HI;
      S_ADDR_HI: nxt = S_READ_HI;
      S_READ_HI: if (mem_ready) nxt = S_ADDR_LO;
      S_ADDR_LO: nxt = S_READ_LO;
      S_READ_LO: if (mem_ready) nxt = S_ISSUE;
      S_ISSUE: begin
        if (instr_ready) begin
          if (halt)            nxt = S_IDLE;
          else if (branch_req) nxt = S_JUMP;
          else                 nxt = S_ADDR_HI;
        end
      end
      S_JUMP:    nxt = S_ADDR_HI;
      default:   nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// Instruction-fetch sequencer on the shared tri-state CPU bus. Each
// instruction is two bus reads (high byte first) assembled into a 2N-bit
// word and offered to execute with a valid/ready handshake. A taken branch
// drives the registered target onto the bus for the PC to load.
//
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   run                        - start fetching from IDLE
//   pc_out/pc_increment/pc_jump- PC strobes (drive / increment / load bus)
//   mar_load                   - MAR latches the bus
//   mem_read, mem_ready        - memory read request / data-valid
//   data                       - shared N-bit bus, driven here only in JUMP
//   instr, instr_valid,
//   instr_ready                - instruction handshake to execute
//   branch_req, branch_target  - redirect request, sampled on accept
//   halt                       - stop after this instruction, sampled on accept
module fetch_ctrl
  import hmmm_fetch_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  output logic           pc_out,
  output logic           pc_increment,
  output logic           pc_jump,
  output logic           mar_load,
  output logic           mem_read,
  input  logic           mem_ready,
  inout  logic [N-1:0]   data,
  output logic [2*N-1:0] instr,
  output logic           instr_valid,
  input  logic           instr_ready,
  input  logic           branch_req,
  input  logic [N-1:0]   branch_target,
  input  logic           halt
);

  // Instruction width; the package value applies to the default bus width.
  localparam int IW = (N == DEFAULT_N) ? INSTR_W : 2 * N;

  fetch_state_e state;
  fetch_state_e state_nxt;
  logic [N-1:0] hi_byte;
  logic [N-1:0] lo_byte;
  logic [N-1:0] target;
  logic [IW-1:0] instr_word;

  assign state_nxt = fetch_next(state, run, mem_ready, instr_ready, halt, branch_req);

  // State register plus the strobes, registered from the next state so each
  // output is a clean flop that matches the state it belongs to. The byte
  // and target registers live here too since they only load on specific
  // state edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pc_out       <= 1'b0;
      pc_increment <= 1'b0;
      mar_load     <= 1'b0;
      mem_read     <= 1'b0;
      instr_valid  <= 1'b0;
      pc_jump      <= 1'b0;
      hi_byte      <= '0;
      lo_byte      <= '0;
      target       <= '0;
    end else begin
      state        <= state_nxt;
      pc_out       <= (state_nxt == S_ADDR_HI) || (state_nxt == S_ADDR_LO);
      pc_increment <= (state_nxt == S_ADDR_HI) || (state_nxt == S_ADDR_LO);
      mar_load     <= (state_nxt == S_ADDR_HI) || (state_nxt == S_ADDR_LO);
      mem_read     <= (state_nxt == S_READ_HI) || (state_nxt == S_READ_LO);
      instr_valid  <= (state_nxt == S_ISSUE);
      pc_jump      <= (state_nxt == S_JUMP);

      if ((state == S_READ_HI) && mem_ready) begin
        hi_byte <= data;
      end
      if ((state == S_READ_LO) && mem_ready) begin
        lo_byte <= data;
      end
      // Target is captured only for a branch that actually gets taken.
      if ((state == S_ISSUE) && instr_ready && !halt && branch_req) begin
        target <= branch_target;
      end
    end
  end

  assign instr_word = {hi_byte, lo_byte};
  assign instr      = instr_word;

  // The only bus driver in this block: the branch target during JUMP.
  assign data = (state == S_JUMP) ? target : {N{1'bz}};

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl. Models the PC, MAR and a 256-byte
// memory on the shared bus, runs a table of directed fetches, a few
// hand-written reset/wrap sequences, then randomized fetches checked
// against an address-level reference model.
module tb_fetch_ctrl;
  import hmmm_fetch_pkg::*;

  localparam int N = 8;
  localparam logic [N-1:0] BUS_IDLE = 8'hFF;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           run;
  logic           pc_out;
  logic           pc_increment;
  logic           pc_jump;
  logic           mar_load;
  logic           mem_read;
  logic           mem_ready;
  wire  [N-1:0]   data;
  logic [2*N-1:0] instr;
  logic           instr_valid;
  logic           instr_ready;
  logic           branch_req;
  logic [N-1:0]   branch_target;
  logic           halt;

  logic [N-1:0] pc;
  logic [N-1:0] mar;
  logic [N-1:0] mem [256];
  logic         pc_force = 1'b0;
  logic [N-1:0] pc_force_val = '0;

  int total = 0;
  int bad = 0;
  logic [N-1:0] model_addr;

  typedef struct {
    int             hw;
    int             lw;
    int             rdy;
    bit             br;
    bit             hlt;
    logic [N-1:0]   tgt;
    logic [2*N-1:0] exp_instr;
    int             exp_cyc;
  } vec_t;

  vec_t vecs[6];

  fetch_ctrl #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .pc_out(pc_out),
    .pc_increment(pc_increment),
    .pc_jump(pc_jump),
    .mar_load(mar_load),
    .mem_read(mem_read),
    .mem_ready(mem_ready),
    .data(data),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch_req(branch_req),
    .branch_target(branch_target),
    .halt(halt)
  );

  always #5 clk = ~clk;

  // Undriven bus reads as all ones so a stray driver is visible.
  pullup (data);

  // Bus-side models: PC drives on pc_out, memory drives on a ready read.
  assign data = pc_out ? pc : 'z;
  assign data = (mem_read && mem_ready) ? mem[mar] : 'z;

  // PC and MAR registers living on the bus.
  always @(posedge clk) begin
    if (pc_force)          pc <= pc_force_val;
    else if (pc_jump)      pc <= data;
    else if (pc_increment) pc <= pc + 8'd1;
    if (mar_load)          mar <= data;
  end

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setPc(input logic [N-1:0] v);
    pc_force = 1'b1;
    pc_force_val = v;
    step();
    pc_force = 1'b0;
  endtask

  task automatic clearInputs();
    mem_ready = 1'b0;
    instr_ready = 1'b0;
    branch_req = 1'b0;
    halt = 1'b0;
    branch_target = '0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_strobes"},
                {26'd0, pc_out, pc_increment, pc_jump, mar_load, mem_read, instr_valid}, 32'd0);
    checkOutput({tag, "_instr"}, instr, 32'd0);
    checkOutput({tag, "_bus"}, data, BUS_IDLE);
  endtask

  // Bus ownership: at most one owner, and nothing on the bus when idle.
  task automatic checkBus();
    int owners;
    owners = int'(pc_out) + int'(mem_read) + int'(pc_jump);
    checkOutput("bus_single_owner", (owners <= 1), 1);
    if (!pc_out && !(mem_read && mem_ready) && !pc_jump)
      checkOutput("bus_idle", data, BUS_IDLE);
  endtask

  task automatic waitAddrHi();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pc_out && pc_increment && mar_load) found = 1'b1;
      else step();
    end
    checkOutput("addr_hi_reached", found, 1);
  endtask

  // Runs one fetch from ADDR_HI up to ISSUE, inserting hw/lw wait cycles.
  task automatic fetchOne(input int hw, input int lw, input bit noisy,
                          output int cycles, output int rd, output int inc);
    int cyc;
    int wcnt;
    int idx;
    cyc = 1; wcnt = 0; idx = 0; rd = 0; inc = 0;
    while (!instr_valid && cyc < 60) begin
      checkBus();
      if (pc_increment) inc++;
      if (mem_read) begin
        rd++;
        mem_ready = (wcnt == ((idx == 0) ? hw : lw));
        if (mem_ready) begin
          wcnt = 0;
          idx++;
        end else begin
          wcnt++;
        end
      end else begin
        mem_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (noisy) begin
        instr_ready = 1'($urandom_range(0, 1));
        branch_req = 1'($urandom_range(0, 1));
        halt = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
    end
    clearInputs();
    cycles = instr_valid ? cyc : -1;
  endtask

  // Holds the instruction for rdy cycles, then accepts it and checks the
  // redirect / halt / continue behaviour against the address model.
  task automatic finishInstr(input int rdy, input bit br, input logic [N-1:0] tgt,
                             input bit hlt, input logic [2*N-1:0] exp_instr);
    logic [2*N-1:0] held;
    logic [N-1:0]   pc_before;
    held = instr;
    checkOutput("instr_value", instr, exp_instr);
    for (int i = 0; i < rdy; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      step();
      checkOutput("stall_valid", instr_valid, 1);
      checkOutput("stall_instr", instr, held);
      checkOutput("stall_strobes", {pc_out, pc_increment, pc_jump, mar_load, mem_read}, 0);
      mem_ready = 1'b0;
    end
    pc_before = pc;
    instr_ready = 1'b1;
    branch_req = br;
    branch_target = tgt;
    halt = hlt;
    step();
    clearInputs();
    branch_target = ~tgt;
    if (hlt) begin
      model_addr = model_addr + 8'd2;
      checkOutput("halt_idle", {pc_out, pc_increment, pc_jump, mar_load, mem_read, instr_valid}, 0);
      checkOutput("halt_pc_unchanged", pc, pc_before);
      checkOutput("halt_pc_model", pc, model_addr);
      step();
      checkOutput("halt_rerun_addr_hi", {pc_out, mar_load, pc_increment, mem_read, instr_valid}, 5'b11100);
      checkOutput("halt_rerun_pc", data, model_addr);
    end else if (br) begin
      model_addr = tgt;
      checkOutput("jump_strobes", {pc_jump, pc_out, mem_read, instr_valid}, 4'b1000);
      checkOutput("jump_bus", data, tgt);
      step();
      checkOutput("jump_addr_hi", {pc_out, mar_load, pc_increment, pc_jump}, 4'b1110);
      checkOutput("jump_pc_on_bus", data, tgt);
    end else begin
      model_addr = model_addr + 8'd2;
      checkOutput("next_addr_hi", {pc_out, mar_load, pc_increment, mem_read, instr_valid}, 5'b11100);
      checkOutput("next_pc_on_bus", data, model_addr);
    end
  endtask

  // Expected instruction at an address, straight from memory contents.
  function automatic logic [2*N-1:0] modelInstr(input logic [N-1:0] a);
    logic [N-1:0] a1;
    a1 = a + 8'd1;
    return {mem[a], mem[a1]};
  endfunction

  task automatic applyStimulus(input int hw, input int lw, input int rdy, input bit br,
                               input bit hlt, input logic [N-1:0] tgt,
                               input logic [2*N-1:0] exp_instr, input int exp_cyc,
                               input bit noisy);
    int cyc;
    int rd;
    int inc;
    waitAddrHi();
    checkOutput("addr_hi_pc", data, model_addr);
    fetchOne(hw, lw, noisy, cyc, rd, inc);
    checkOutput("fetch_cycles", cyc, exp_cyc);
    checkOutput("mem_read_cycles", rd, hw + lw + 2);
    checkOutput("pc_increments", inc, 2);
    if (cyc > 0) finishInstr(rdy, br, tgt, hlt, exp_instr);
  endtask

  initial begin
    int cyc;
    int rd;
    int inc;

    // Memory holds the inverted address except for a couple of known bytes.
    for (int i = 0; i < 256; i++) mem[i] = ~8'(i);
    mem[8'h10] = 8'hAB;
    mem[8'h11] = 8'hCD;

    //            hw lw rdy br hlt tgt    instr      cyc
    vecs[0] = '{0, 0, 0, 1'b0, 1'b0, 8'h00, 16'hABCD, 5};
    vecs[1] = '{3, 3, 0, 1'b1, 1'b0, 8'h40, 16'hEDEC, 11};
    vecs[2] = '{1, 0, 6, 1'b1, 1'b1, 8'h77, 16'hBFBE, 6};
    vecs[3] = '{0, 2, 2, 1'b0, 1'b0, 8'h00, 16'hBDBC, 7};
    vecs[4] = '{2, 1, 0, 1'b1, 1'b0, 8'hFF, 16'hBBBA, 8};
    vecs[5] = '{0, 0, 1, 1'b0, 1'b0, 8'h00, 16'h00FF, 5};

    // Reset and idle behaviour.
    rst_n = 1'b0;
    run = 1'b0;
    clearInputs();
    setPc(8'h10);
    step();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    step();
    step();
    checkResetOutputs("idle_no_run");
    run = 1'b1;
    model_addr = 8'h10;

    // Directed table.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].hw, vecs[i].lw, vecs[i].rdy, vecs[i].br, vecs[i].hlt,
                    vecs[i].tgt, vecs[i].exp_instr, vecs[i].exp_cyc, 1'b0);
    end

    // Reset in the middle of READ_LO: the read aborts and the high byte is lost.
    waitAddrHi();
    step();
    checkOutput("rst_seq_read_hi", mem_read, 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    checkOutput("rst_seq_read_lo", mem_read, 1);
    step();
    #2;
    rst_n = 1'b0;
    run = 1'b0;
    #1;
    checkResetOutputs("rst_mid_read_lo");
    step();

    // Reset while fetching across the PC wrap, then a clean wrap fetch.
    setPc(8'hFF);
    rst_n = 1'b1;
    run = 1'b1;
    model_addr = 8'hFF;
    waitAddrHi();
    checkOutput("wrap_pc_ff", data, 8'hFF);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("rst_at_wrap");
    setPc(8'hFF);
    rst_n = 1'b1;
    waitAddrHi();
    checkOutput("wrap_rerun_pc", data, 8'hFF);
    fetchOne(0, 0, 1'b0, cyc, rd, inc);
    checkOutput("wrap_cycles", cyc, 5);
    if (cyc > 0) finishInstr(0, 1'b0, 8'h00, 1'b1, 16'h00FF);

    // Randomized fetches against the address model.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int k = 0; k < 30; k++) begin
      int hw;
      int lw;
      int rdy;
      bit br;
      bit hlt;
      logic [N-1:0] tgt;
      hw  = $urandom_range(0, 3);
      lw  = $urandom_range(0, 3);
      rdy = $urandom_range(0, 3);
      br  = ($urandom_range(0, 3) == 0);
      hlt = ($urandom_range(0, 6) == 0);
      tgt = 8'($urandom_range(0, 254));
      applyStimulus(hw, lw, rdy, br, hlt, tgt, modelInstr(model_addr), 5 + hw + lw, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
